// File: rtl/seg7_pkg.sv
// Shared types and constants for the HY-207 seven-segment count display.
package seg7_pkg;

  localparam int unsigned NIB_W = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low a..g patterns for BCD 0-9, entry 0 at the low end; dp (bit 7) kept off.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef logic [NIB_W-1:0] bcd_nib_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // Codes 10-15 never come out of the converter; show them blank.
  function automatic logic [7:0] seg_decode(input bcd_nib_t nib);
    if (nib > 4'd9) return SEG_OFF;
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep, newest-wins pending load.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned VAL_W  = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VAL_W-1:0]      value_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  done_c,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  conv_state_e        state_q, state_d;
  logic [VAL_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [VAL_W-1:0]   pend_val_q, pend_val_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    done_c     = 1'b0;

    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    // Any load outside IDLE parks in the pending slot; DONE consumes it below.
    if (load_i && state_q != IDLE) begin
      pend_d     = 1'b1;
      pend_val_d = value_i;
    end

    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          shift_d   = value_i;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shift_q[VAL_W-1]};
        shift_d   = {shift_q[VAL_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) state_d = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (pend_q || load_i) begin
          shift_d   = load_i ? value_i : pend_val_q;
          pend_d    = 1'b0;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = busy_q;
  assign bcd_o  = scratch_q;

endmodule

// File: rtl/seg7_count_display.sv
// Count display: BCD conversion, atomic display update, multiplexed 7-seg scan.
// Build option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int unsigned VAL_W    = 7,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VAL_W-1:0]   value_i,
  input  logic               load_i,
  output logic               busy_o,
  output logic [7:0]         seg_o,
  output logic [DIGITS-1:0]  dig_o
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  disp_q;
  logic              done_c;
  logic [SCAN_W-1:0] scan_q;
  logic [IDX_W-1:0]  idx_q;
  bcd_nib_t          sel_nib;
  logic              blank;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] dig_d;

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value_i),
    .load_i  (load_i),
    .busy_o  (busy_o),
    .done_c  (done_c),
    .bcd_o   (scratch)
  );

  // Display only changes on a finished conversion, never mid-shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= '0;
    else if (done_c) disp_q <= scratch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  always_comb begin
    sel_nib = '0;
    blank   = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib = disp_q[4*i +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = (i != 0) && ((disp_q >> (4 * i)) == '0);
`endif
      end
    end
    seg_d = blank ? SEG_OFF : seg_decode(sel_nib);
    dig_d = ~(DIGITS'(1) << idx_q);
  end

  // seg_o and dig_o share one register stage so they switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_OFF;
      dig_o <= '1;
    end else begin
      seg_o <= seg_d;
      dig_o <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display with a shortened scan period.
module tb_seg7_count_display;

  localparam int unsigned VAL_W    = 7;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned SCAN_DIV = 3;

  typedef struct {
    logic [6:0] val;
    logic [7:0] s2;
    logic [7:0] s1;
    logic [7:0] s0;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [VAL_W-1:0]  value_i = '0;
  logic              load_i = 1'b0;
  logic              busy_o;
  logic [7:0]        seg_o;
  logic [DIGITS-1:0] dig_o;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs [9];
  vec_t prev;

  seg7_count_display #(
    .VAL_W    (VAL_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value_i),
    .load_i  (load_i),
    .busy_o  (busy_o),
    .seg_o   (seg_o),
    .dig_o   (dig_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each cycle, seg_o must match the expected digit for whichever digit dig_o selects.
  task automatic check_disp(input vec_t v, input int ncyc, input string name);
    logic [7:0] exp;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      case (dig_o)
        3'b110:  exp = v.s0;
        3'b101:  exp = v.s1;
        3'b011:  exp = v.s2;
        default: exp = 8'h00;
      endcase
      if (exp == 8'h00) chk({name, "_dig"}, 32'(dig_o), 32'h7);
      else              chk(name, 32'(seg_o), 32'(exp));
    end
  endtask

  task automatic load_pulse(input logic [6:0] v);
    @(negedge clk);
    load_i  = 1'b1;
    value_i = v;
    @(posedge clk);
    #1 load_i = 1'b0;
  endtask

  initial begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[0] = '{7'd0,   8'hFF, 8'hFF, 8'hC0};
    vecs[1] = '{7'd127, 8'hF9, 8'hA4, 8'hF8};
    vecs[2] = '{7'd5,   8'hFF, 8'hFF, 8'h92};
    vecs[3] = '{7'd108, 8'hF9, 8'hC0, 8'h80};
    vecs[4] = '{7'd99,  8'hFF, 8'h90, 8'h90};
    vecs[5] = '{7'd42,  8'hFF, 8'h99, 8'hA4};
    vecs[6] = '{7'd100, 8'hF9, 8'hC0, 8'hC0};
    vecs[7] = '{7'd10,  8'hFF, 8'hF9, 8'hC0};
    vecs[8] = '{7'd3,   8'hFF, 8'hFF, 8'hB0};
`else
    vecs[0] = '{7'd0,   8'hC0, 8'hC0, 8'hC0};
    vecs[1] = '{7'd127, 8'hF9, 8'hA4, 8'hF8};
    vecs[2] = '{7'd5,   8'hC0, 8'hC0, 8'h92};
    vecs[3] = '{7'd108, 8'hF9, 8'hC0, 8'h80};
    vecs[4] = '{7'd99,  8'hC0, 8'h90, 8'h90};
    vecs[5] = '{7'd42,  8'hC0, 8'h99, 8'hA4};
    vecs[6] = '{7'd100, 8'hF9, 8'hC0, 8'hC0};
    vecs[7] = '{7'd10,  8'hC0, 8'hF9, 8'hC0};
    vecs[8] = '{7'd3,   8'hC0, 8'hC0, 8'hB0};
`endif

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(seg_o), 32'hFF);
    chk("rst_dig", 32'(dig_o), 32'h7);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b1;

    // Scan order and slot length
    begin
      logic [2:0] last;
      logic [2:0] order [4];
      int cnt;
      order[0] = 3'b101; order[1] = 3'b011; order[2] = 3'b110; order[3] = 3'b101;
      cnt = 0;
      while (dig_o == 3'b111 && cnt < 10) begin @(negedge clk); cnt++; end
      chk("scan_first", 32'(dig_o), 32'h6);
      for (int k = 0; k < 4; k++) begin
        last = dig_o;
        cnt = 0;
        while (dig_o == last && cnt < 4 * SCAN_DIV) begin @(negedge clk); cnt++; end
        chk("scan_period", 32'(cnt), 32'(SCAN_DIV));
        chk("scan_order", 32'(dig_o), 32'(order[k]));
      end
    end
    check_disp(vecs[0], 3 * SCAN_DIV, "post_rst_disp");

    // Table: busy length, exact update latency, then decoded content
    prev = vecs[0];
    for (int t = 1; t < 5; t++) begin
      int busy_cnt;
      load_pulse(vecs[t].val);
      busy_cnt = 0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        busy_cnt += int'(busy_o);
      end
      chk("busy_len", 32'(busy_cnt), 32'd8);
      check_disp(prev, 1, "hold_old");
      chk("busy_clear", 32'(busy_o), 32'h0);
      check_disp(vecs[t], 3 * SCAN_DIV, "table_disp");
      prev = vecs[t];
    end

    // 42 loaded, then 99 and 100 during SHIFT: 042 then 100, never 99
    load_pulse(vecs[5].val);
    load_pulse(vecs[4].val);
    load_pulse(vecs[6].val);
    check_disp(prev, 7, "pend_hold_old");
    chk("pend_busy", 32'(busy_o), 32'h1);
    check_disp(vecs[5], 8, "pend_first");
    check_disp(vecs[6], 9, "pend_newest");
    chk("pend_idle", 32'(busy_o), 32'h0);
    prev = vecs[6];

    // Load in the DONE cycle of 10 with value 3
    load_pulse(vecs[7].val);
    check_disp(prev, 7, "done_hold_old");
    load_pulse(vecs[8].val);
    check_disp(prev, 1, "done_hold_old2");
    check_disp(vecs[7], 8, "done_first");
    check_disp(vecs[8], 9, "done_second");

    // Reset in the middle of converting 127
    load_pulse(vecs[1].val);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg_o), 32'hFF);
    chk("midrst_dig", 32'(dig_o), 32'h7);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    check_disp(vecs[0], 12, "midrst_disp");
    chk("midrst_idle", 32'(busy_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Downstream stage of the press counter and lamp-sum logic on the HY-207 board.
- Takes the 7-bit press/lamp count and converts it to three BCD digits with a sequential double-dabble.
- Drives the multiplexed 7-segment display: segment lines pin91..pin1, digit selects pin2..pin4.
- Display content updates atomically, only when a conversion finishes.

Parameters:
- VAL_W, 7, width of the binary input value (max 127).
- DIGITS, 3, number of display digits; digit 0 is ones.
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz board oscillator.
- rst_n  in  1  asynchronous active-low reset.
- value_i  in  VAL_W  binary count to display.
- load_i  in  1  single-cycle strobe; samples value_i.
- busy_o  out  1  high while a conversion is in progress.
- seg_o  out  8  active-low segments: [0]=a .. [6]=g, [7]=dp.
- dig_o  out  DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (asynchronous, active-low, applies mid-operation):
  - seg_o=8'hFF, dig_o all 1, busy_o=0.
  - Displayed BCD registers = 0, pending flag cleared, scan counter = 0, digit index = 0.
  - FSM to IDLE; any in-flight conversion is discarded.
- FSM:
  - IDLE: when load_i=1, capture value_i into the shift register, clear BCD scratch, go to SHIFT, busy_o=1 next cycle.
  - SHIFT: runs exactly VAL_W cycles. Each cycle, add 3 to every scratch nibble >=5, then shift left by 1 with the value MSB entering. After the VAL_W-th shift, go to DONE.
  - DONE: copy the scratch nibbles to the displayed registers in one cycle. If the pending flag is set, reload from the pending value, clear the flag and go to SHIFT. Otherwise go to IDLE and busy_o=0.
- Latency: display registers hold the new value VAL_W+2 cycles after the load_i cycle (9 cycles at defaults).
- load_i while busy:
  - value_i is stored in the pending register and the pending flag is set.
  - A later load overwrites it; only the newest pending value is kept.
  - No load is ever lost except superseded pending ones.
- load_i in the same cycle as DONE: treated as pending and honoured immediately on that DONE.
- Scan:
  - Free-running counter 0..SCAN_DIV-1.
  - At wrap, the digit index advances 0->1->..->DIGITS-1->0.
  - dig_o drives bit[index] low and all others high.
  - seg_o is the registered decode of the selected digit and changes in the same cycle as dig_o, so there is no ghost cycle.
- Decode:
  - BCD 0-9 maps to standard patterns.
  - Nibble codes 10-15 cannot occur; they decode to 8'hFF (blank).
  - dp is always off (bit7=1).
- Width: scratch is 4*DIGITS bits; values up to 10^DIGITS-1 are representable, and the default 127 fits.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit that is zero and has only zeros in all higher digits outputs seg_o=8'hFF. Digit 0 always shows. Examples: 5 shows "  5"; 0 shows "  0".
- Undefined: all digits always show, with leading zeros ("005").

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF (8'hFF).
  - The 10-entry active-low segment table, e.g. 0=8'hC0, 1=8'hF9, 2=8'hA4, 7=8'hF8.
  - The FSM state enum (IDLE, SHIFT, DONE).
  - BCD nibble typedef.
- One sub-module: bin2bcd_seq. It holds the FSM, the pending register and the busy logic, and exposes a done pulse plus the BCD bus.
- Scan and decode stay in the top of the block.

Test Plan:
- Reset mid-SHIFT (assert rst_n=0 at cycle 3 after loading 127) -> seg_o=8'hFF, dig_o=3'b111, busy_o=0 asynchronously. After release, digits read 0.
- Load 127 -> busy_o high for 8 cycles; 9 cycles after load, digits are 1,2,7. Scanning gives seg_o 8'hF8 (dig_o=3'b110), 8'hA4 (3'b101), 8'hF9 (3'b011).
- Load 42, then load 99 and 100 during SHIFT -> display shows 042 first, then 100. 99 is never displayed.
- Load 0 with the macro defined -> digit0 shows 8'hC0, digits 1-2 show 8'hFF. Without the macro, all three show 8'hC0.
- Scan timing: count clk between dig_o changes -> exactly SCAN_DIV. Order is 3'b110 -> 3'b101 -> 3'b011 -> 3'b110.
- load_i asserted in the DONE cycle of value 10 together with value_i=3 -> 010 is displayed, then 003 exactly VAL_W+1 cycles later.
